// File: rtl/gram_pkg.sv
// rtl/gram_pkg.sv - shared types and width helpers for the Gram/RAT/matrix-vector engine
package gram_pkg;

   typedef enum logic [2:0] {LOAD, DRAIN, RAT, WGT, MAC, OUT} state_t;

   // Counter width that stays at least one bit for a count of 1.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int g_w(input int dw, input int l);
      return 2 * dw + $clog2(l);
   endfunction

   function automatic bit width_ok(input int n, input int l, input int dw, input int ow);
      return (ow >= 3 * dw + $clog2(l) + $clog2(n)) && (n >= 2) && ((n & (n - 1)) == 0) && (l >= 1);
   endfunction

endpackage

// File: rtl/gram_mac_lane.sv
// rtl/gram_mac_lane.sv - N registered multipliers (vector a times scalar b) with optional accumulators
module gram_mac_lane
#(
   parameter int N   = 8,
   parameter int AW  = 8,
   parameter int BW  = 8,
   parameter int SW  = 16,
   parameter bit SGN = 1'b0,
   parameter bit ACC = 1'b1
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clr,
   input  logic [AW-1:0] a [N],
   input  logic [BW-1:0] b,
   output logic [SW-1:0] sum [N]
);

   localparam int PW = AW + BW;

   logic [PW-1:0] prod [N];

   function automatic logic [PW-1:0] mul(input logic [AW-1:0] x, input logic [BW-1:0] y);
      logic signed [AW:0]   xs;
      logic signed [BW:0]   ys;
      logic signed [PW-1:0] f;
      xs = $signed({x[AW-1] & SGN, x});
      ys = $signed({y[BW-1] & SGN, y});
      f  = PW'(xs) * PW'(ys);
      return f;
   endfunction

   function automatic logic [SW-1:0] ext(input logic [PW-1:0] p);
      return SGN ? SW'($signed(p)) : SW'(p);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || clr) begin
         for (int i = 0; i < N; i++) prod[i] <= '0;
      end else if (en) begin
         for (int i = 0; i < N; i++) prod[i] <= mul(a[i], b);
      end
   end

   generate
      if (ACC) begin : g_acc
         logic          vld;
         logic [SW-1:0] acc [N];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n || clr) begin
               vld <= 1'b0;
               for (int i = 0; i < N; i++) acc[i] <= '0;
            end else begin
               vld <= en;
               if (vld) begin
                  for (int i = 0; i < N; i++) acc[i] <= acc[i] + ext(prod[i]);
               end
            end
         end

         always_comb begin
            for (int i = 0; i < N; i++) sum[i] = acc[i];
         end
      end else begin : g_pass
         always_comb begin
            for (int i = 0; i < N; i++) sum[i] = ext(prod[i]);
         end
      end
   endgenerate

endmodule

// File: rtl/gram_rat_mv.sv
// rtl/gram_rat_mv.sv - streaming Gram matrix, row-average threshold, then y = G'*w (GRAM_RAT_BYPASS_EN adds rat_bypass)
module gram_rat_mv
   import gram_pkg::*;
#(
   parameter int N      = 8,
   parameter int L      = 16,
   parameter int DW     = 8,
   parameter int OW     = 32,
   parameter int SIGNED = 0
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_valid,
   output logic          i_ready,
   input  logic [DW-1:0] i_data,
   input  logic          w_valid,
   output logic          w_ready,
   input  logic [DW-1:0] w_data,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [OW-1:0] o_data
`ifdef GRAM_RAT_BYPASS_EN
   ,
   input  logic          rat_bypass
`endif
);

   localparam int G_W  = g_w(DW, L);
   localparam int NW   = cnt_w(N);
   localparam int CW   = cnt_w(L);
   localparam int LN   = $clog2(N);
   localparam int SUMW = G_W + LN + 1;
   localparam bit SGN  = (SIGNED != 0);
   localparam logic [NW-1:0] N_LAST = NW'(N - 1);
   localparam logic [CW-1:0] L_LAST = CW'(L - 1);

   generate
      if (!width_ok(N, L, DW, OW)) begin : g_param_check
         $error("gram_rat_mv: illegal N/L/DW/OW combination");
      end
   endgenerate

   state_t state, state_nxt;
   logic [CW-1:0] col;
   logic [NW-1:0] row, wix, oix, g_row;
   logic          mac_wait, g_vld, rat_en;
   logic          i_hs, w_hs, o_hs, last_out;
   logic [DW-1:0]  xbuf [N][L];
   logic [G_W-1:0] gram [N][N];
   logic [DW-1:0]  g_a   [N];
   logic [G_W-1:0] g_sum [N];
   logic [G_W-1:0] m_a   [N];
   logic [OW-1:0]  y_acc [N];
   logic signed [SUMW-1:0] avg [N];

   // Zero-extension plus a spare sign bit lets one signed compare serve both modes.
   function automatic logic signed [SUMW-1:0] gext(input logic [G_W-1:0] g);
      return SGN ? SUMW'($signed(g)) : SUMW'(g);
   endfunction

   assign i_hs     = i_valid && (state == LOAD);
   assign w_hs     = w_valid && (state == WGT);
   assign o_hs     = o_ready && (state == OUT);
   assign last_out = o_hs && (oix == N_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      i_ready   = 1'b0;
      w_ready   = 1'b0;
      o_valid   = 1'b0;
      o_data    = '0;
      case (state)
         LOAD: begin
            i_ready = 1'b1;
            if (i_valid && row == N_LAST && col == L_LAST) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = RAT;
         RAT:   state_nxt = WGT;
         WGT: begin
            w_ready = 1'b1;
            if (w_valid && wix == N_LAST) state_nxt = MAC;
         end
         MAC: if (mac_wait) state_nxt = OUT;
         OUT: begin
            o_valid = 1'b1;
            o_data  = y_acc[oix];
            if (o_ready && oix == N_LAST) state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row      <= '0;
         col      <= '0;
         wix      <= '0;
         oix      <= '0;
         mac_wait <= 1'b0;
      end else begin
         if (i_hs) begin
            if (col == L_LAST) begin
               col <= '0;
               row <= (row == N_LAST) ? '0 : row + NW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         if (w_hs)          wix      <= (wix == N_LAST) ? '0 : wix + NW'(1);
         if (state == MAC)  mac_wait <= ~mac_wait;
         if (o_hs)          oix      <= (oix == N_LAST) ? '0 : oix + NW'(1);
      end
   end

`ifdef GRAM_RAT_BYPASS_EN
   logic bypass_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              bypass_q <= 1'b0;
      else if (state == DRAIN) bypass_q <= rat_bypass;
   end
   assign rat_en = (state == RAT) && !bypass_q;
`else
   assign rat_en = (state == RAT);
`endif

   // Lane j pairs the incoming sample with the stored sample of row j in the same column.
   always_comb begin
      for (int j = 0; j < N; j++) begin
         g_a[j] = (NW'(j) == row) ? i_data : xbuf[j][col];
         m_a[j] = gram[j][wix];
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         logic signed [SUMW-1:0] rsum;
         rsum = '0;
         for (int j = 0; j < N; j++) rsum = rsum + gext(gram[i][j]);
         avg[i] = rsum >>> LN;
      end
   end

   gram_mac_lane #(.N(N), .AW(DW), .BW(DW), .SW(G_W), .SGN(SGN), .ACC(1'b0)) u_gram_lane (
      .clk(clk), .rst_n(rst_n), .en(i_hs), .clr(last_out), .a(g_a), .b(i_data), .sum(g_sum)
   );

   gram_mac_lane #(.N(N), .AW(G_W), .BW(DW), .SW(OW), .SGN(SGN), .ACC(1'b1)) u_mv_lane (
      .clk(clk), .rst_n(rst_n), .en(w_hs), .clr(last_out), .a(m_a), .b(w_data), .sum(y_acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_vld <= 1'b0;
         g_row <= '0;
         for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) gram[i][j] <= '0;
         for (int i = 0; i < N; i++) for (int c = 0; c < L; c++) xbuf[i][c] <= '0;
      end else if (last_out) begin
         g_vld <= 1'b0;
         g_row <= '0;
         for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) gram[i][j] <= '0;
         for (int i = 0; i < N; i++) for (int c = 0; c < L; c++) xbuf[i][c] <= '0;
      end else begin
         g_vld <= i_hs;
         g_row <= row;
         if (i_hs) xbuf[row][col] <= i_data;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               if (rat_en) begin
                  if (gext(gram[i][j]) < avg[i]) gram[i][j] <= '0;
               end else if (g_vld) begin
                  if (NW'(i) == g_row && NW'(j) <= g_row)
                     gram[i][j] <= gram[i][j] + g_sum[j];
                  else if (NW'(j) == g_row && NW'(i) < g_row)
                     gram[i][j] <= gram[i][j] + g_sum[i];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_gram_rat_mv.sv
// tb/tb_gram_rat_mv.sv - directed bench driving an unsigned and a signed instance in lockstep
module tb_gram_rat_mv;

   localparam int N  = 8;
   localparam int L  = 16;
   localparam int DW = 8;
   localparam int OW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          i_valid, w_valid, o_ready;
   logic [DW-1:0] i_data, w_data;
   logic          i_ready, w_ready, o_valid;
   logic [OW-1:0] o_data;
   logic          s_i_ready, s_w_ready, s_o_valid;
   logic [OW-1:0] s_o_data;
`ifdef GRAM_RAT_BYPASS_EN
   logic          rat_bypass;
`endif

   gram_rat_mv #(.N(N), .L(L), .DW(DW), .OW(OW), .SIGNED(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
`ifdef GRAM_RAT_BYPASS_EN
      , .rat_bypass(rat_bypass)
`endif
   );

   gram_rat_mv #(.N(N), .L(L), .DW(DW), .OW(OW), .SIGNED(1)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .i_valid(i_valid), .i_ready(s_i_ready), .i_data(i_data),
      .w_valid(w_valid), .w_ready(s_w_ready), .w_data(w_data),
      .o_valid(s_o_valid), .o_ready(o_ready), .o_data(s_o_data)
`ifdef GRAM_RAT_BYPASS_EN
      , .rat_bypass(rat_bypass)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [OW-1:0] yu [N];
   logic [OW-1:0] ys [N];
   int            wr_lat, ov_lat, hold_err;
   logic          drop_iready, post_iready, post_ovalid;
   logic [OW-1:0] post_odata;

   // Drives one full job; xmode 1 gives x[r][c] = r+1, otherwise every sample is xval.
   task automatic run_job(input int xmode, input logic [DW-1:0] xval, input logic [DW-1:0] wval,
                          input int gap, input int stall);
      int k, cyc;
      logic          stalled;
      logic [OW-1:0] prev;
      k = 0; cyc = 0;
      while (k < N * L && cyc < 5000) begin
         @(negedge clk); cyc++;
         i_valid = ($urandom_range(99) >= gap);
         i_data  = (xmode == 1) ? DW'(k / L + 1) : xval;
         if (i_valid && i_ready) k++;
      end
      n_cmp++;
      if (k != N * L) begin n_bad++; $display("FAIL sample_timeout: accepted %0d required %0d", k, N * L); end
      @(negedge clk);
      i_valid = 1'b0;
      drop_iready = i_ready;
      wr_lat = 1;
      while (!w_ready && wr_lat < 50) begin @(negedge clk); wr_lat++; end
      k = 0; cyc = 0;
      while (k < N && cyc < 2000) begin
         @(negedge clk); cyc++;
         w_valid = ($urandom_range(99) >= gap);
         w_data  = wval;
         if (w_valid && w_ready) k++;
      end
      n_cmp++;
      if (k != N) begin n_bad++; $display("FAIL weight_timeout: accepted %0d required %0d", k, N); end
      @(negedge clk);
      w_valid = 1'b0;
      ov_lat = 1;
      while (!o_valid && ov_lat < 50) begin @(negedge clk); ov_lat++; end
      k = 0; cyc = 0; hold_err = 0; stalled = 1'b0; prev = '0;
      while (k < N && cyc < 2000) begin
         if (stalled && (o_valid !== 1'b1 || o_data !== prev)) hold_err++;
         stalled = 1'b0;
         o_ready = ($urandom_range(99) >= stall);
         if (o_valid === 1'b1) begin
            if (o_ready) begin yu[k] = o_data; ys[k] = s_o_data; k++; end
            else begin stalled = 1'b1; prev = o_data; end
         end
         @(negedge clk); cyc++;
      end
      n_cmp++;
      if (k != N) begin n_bad++; $display("FAIL output_timeout: got %0d outputs required %0d", k, N); end
      o_ready     = 1'b0;
      post_iready = i_ready;
      post_ovalid = o_valid;
      post_odata  = o_data;
   endtask

   task automatic test_reset;
      n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL reset_i_ready: got %b required 1", i_ready); end
      n_cmp++; if (w_ready !== 1'b0) begin n_bad++; $display("FAIL reset_w_ready: got %b required 0", w_ready); end
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid: got %b required 0", o_valid); end
      n_cmp++; if (o_data !== 32'd0) begin n_bad++; $display("FAIL reset_o_data: got %0h required 0", o_data); end
      n_cmp++; if (s_i_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_i_ready: got %b required 1", s_i_ready); end
   endtask

   task automatic test_ones;
      run_job(0, 8'd1, 8'd1, 0, 0);
      n_cmp++; if (wr_lat != 3) begin n_bad++; $display("FAIL ones_w_ready_latency: got %0d required 3", wr_lat); end
      n_cmp++; if (ov_lat != 3) begin n_bad++; $display("FAIL ones_o_valid_latency: got %0d required 3", ov_lat); end
      n_cmp++; if (drop_iready !== 1'b0) begin n_bad++; $display("FAIL ones_i_ready_drop: got %b required 0", drop_iready); end
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (yu[i] !== 32'd128) begin n_bad++; $display("FAIL ones_y[%0d]: got %0d required 128", i, yu[i]); end
      end
      n_cmp++; if (post_iready !== 1'b1) begin n_bad++; $display("FAIL ones_back_to_load: got %b required 1", post_iready); end
   endtask

   task automatic test_ramp;
      run_job(1, 8'd0, 8'd1, 0, 0);
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (yu[i] !== OW'(416 * (i + 1))) begin n_bad++; $display("FAIL ramp_y[%0d]: got %0d required %0d", i, yu[i], 416 * (i + 1)); end
      end
   endtask

   task automatic test_max;
      run_job(0, 8'd255, 8'd255, 0, 0);
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (yu[i] !== 32'd2122416000) begin n_bad++; $display("FAIL max_y[%0d]: got %0d required 2122416000", i, yu[i]); end
      end
   endtask

   task automatic test_gaps;
      run_job(1, 8'd0, 8'd1, 50, 50);
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (yu[i] !== OW'(416 * (i + 1))) begin n_bad++; $display("FAIL gaps_y[%0d]: got %0d required %0d", i, yu[i], 416 * (i + 1)); end
      end
      n_cmp++; if (wr_lat != 3) begin n_bad++; $display("FAIL gaps_w_ready_latency: got %0d required 3", wr_lat); end
      n_cmp++; if (ov_lat != 3) begin n_bad++; $display("FAIL gaps_o_valid_latency: got %0d required 3", ov_lat); end
      n_cmp++; if (hold_err != 0) begin n_bad++; $display("FAIL gaps_hold: got %0d violations required 0", hold_err); end
      n_cmp++; if (post_iready !== 1'b1) begin n_bad++; $display("FAIL gaps_i_ready_after: got %b required 1", post_iready); end
      n_cmp++; if (post_ovalid !== 1'b0) begin n_bad++; $display("FAIL gaps_o_valid_after: got %b required 0", post_ovalid); end
      n_cmp++; if (post_odata !== 32'd0) begin n_bad++; $display("FAIL gaps_o_data_after: got %0h required 0", post_odata); end
   endtask

   task automatic test_reset_mid;
      int k, cyc;
      k = 0; cyc = 0;
      while (k < 70 && cyc < 500) begin
         @(negedge clk); cyc++;
         i_valid = 1'b1;
         i_data  = 8'd7;
         if (i_ready) k++;
      end
      @(negedge clk);
      i_valid = 1'b0;
      rst_n   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_i_ready: got %b required 1", i_ready); end
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_o_valid: got %b required 0", o_valid); end
      run_job(0, 8'd1, 8'd1, 0, 0);
      n_cmp++; if (wr_lat != 3) begin n_bad++; $display("FAIL midreset_w_ready_latency: got %0d required 3", wr_lat); end
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (yu[i] !== 32'd128) begin n_bad++; $display("FAIL midreset_y[%0d]: got %0d required 128", i, yu[i]); end
      end
   endtask

   task automatic test_signed;
      run_job(0, 8'hFF, 8'hFE, 0, 0);
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (ys[i] !== 32'hFFFFFF00) begin n_bad++; $display("FAIL signed_y[%0d]: got %0h required ffffff00", i, ys[i]); end
      end
   endtask

`ifdef GRAM_RAT_BYPASS_EN
   task automatic test_bypass;
      rat_bypass = 1'b1;
      run_job(1, 8'd0, 8'd1, 0, 0);
      rat_bypass = 1'b0;
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (yu[i] !== OW'(576 * (i + 1))) begin n_bad++; $display("FAIL bypass_y[%0d]: got %0d required %0d", i, yu[i], 576 * (i + 1)); end
      end
   endtask
`endif

   initial begin
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      w_valid = 1'b0;
      w_data  = '0;
      o_ready = 1'b0;
`ifdef GRAM_RAT_BYPASS_EN
      rat_bypass = 1'b0;
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_ones();
      test_ramp();
      test_max();
      test_gaps();
      test_reset_mid();
      test_signed();
`ifdef GRAM_RAT_BYPASS_EN
      test_bypass();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
